data_memory_mmio: RTL and testbench

- Data-side memory stage directly downstream of the single-cycle CPU core.
- Consumes the core's data_memory_addr, write_data and mem_write, and returns read_data in the same cycle.
- Contains word RAM plus a small memory-mapped I/O region: free-running cycle counter, LED register, and a byte-wide TX FIFO with valid/ready drain toward a future UART.

---
 rtl/data_memory_pkg.sv | 42 ++++
 rtl/data_memory_mmio_tx_fifo.sv | 52 +++++
 rtl/data_memory_mmio.sv | 104 ++++++++++
 tb/tb_data_memory_mmio.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared address map, TXSTAT layout and region decode for the data-side memory stage.
package data_memory_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h0;
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'h4;
    localparam logic [31:0] TXSTAT_ADDR = MMIO_BASE + 32'h8;
    localparam logic [31:0] LED_ADDR    = MMIO_BASE + 32'hC;

    localparam int TXSTAT_FULL_BIT  = 0;
    localparam int TXSTAT_EMPTY_BIT = 1;
    localparam int TXSTAT_OVF_BIT   = 2;
    localparam int TXSTAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_CYCLE,
        REGION_TXDATA,
        REGION_TXSTAT,
        REGION_LED,
        REGION_NONE
    } region_t;

    // Word-granular decode; the low two address bits never participate.
    function automatic region_t decode_region(input logic [31:0] addr, input logic [31:0] ram_bytes);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr < ram_bytes)
            return REGION_RAM;
        else if (word_addr == CYCLE_ADDR)
            return REGION_CYCLE;
        else if (word_addr == TXDATA_ADDR)
            return REGION_TXDATA;
        else if (word_addr == TXSTAT_ADDR)
            return REGION_TXSTAT;
        else if (word_addr == LED_ADDR)
            return REGION_LED;
        else
            return REGION_NONE;
    endfunction

endpackage

// File: rtl/data_memory_mmio_tx_fifo.sv
// Byte FIFO feeding the future UART; push/pop must arrive already qualified by full/empty.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    // Storage has no reset; only the pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory stage: word RAM plus cycle counter, LED register and TX FIFO behind MMIO.
module data_memory_mmio
    import data_memory_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_memory_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [7:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_t       region;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycle_reg;
    logic [7:0]    led_reg;
    logic          overflow_reg;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   txstat;

    assign region  = decode_region(data_memory_addr, RAM_BYTES);
    assign ram_idx = data_memory_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (mem_write && region == REGION_RAM)
            ram[ram_idx] <= write_data;
    end

    // A store to CYCLE replaces the increment for that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_reg    <= '0;
            led_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (mem_write && region == REGION_CYCLE)
                cycle_reg <= write_data;
            else
                cycle_reg <= cycle_reg + 32'd1;
            if (mem_write && region == REGION_LED)
                led_reg <= write_data[7:0];
            if (mem_write && region == REGION_TXDATA && fifo_full)
                overflow_reg <= 1'b1;
            else if (mem_write && region == REGION_TXSTAT && write_data[TXSTAT_OVF_BIT])
                overflow_reg <= 1'b0;
        end
    end

    // Full is judged before the edge, so a concurrent pop cannot make room.
    assign fifo_push = mem_write && region == REGION_TXDATA && !fifo_full;
    assign fifo_pop  = !fifo_empty && tx_ready;

    tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (write_data[7:0]),
        .pop       (fifo_pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;
    assign led      = led_reg;

    always_comb begin
        txstat                              = '0;
        txstat[TXSTAT_FULL_BIT]             = fifo_full;
        txstat[TXSTAT_EMPTY_BIT]            = fifo_empty;
        txstat[TXSTAT_OVF_BIT]              = overflow_reg;
        txstat[TXSTAT_COUNT_LSB +: CW]      = fifo_count;
    end

    always_comb begin
        read_data = '0;
        case (region)
            REGION_RAM:    read_data = ram[ram_idx];
            REGION_CYCLE:  read_data = cycle_reg;
            REGION_TXSTAT: read_data = txstat;
            REGION_LED:    read_data = {24'h0, led_reg};
            default:       read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed vector bench for data_memory_mmio: RAM, cycle counter, LED and TX FIFO behaviour.
module tb_data_memory_mmio;

    logic        clk;
    logic        rst_n;
    logic        mem_write;
    logic [31:0] data_memory_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [7:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks;
    int n_fail;

    localparam logic [31:0] A_CYC = 32'h8000_0000;
    localparam logic [31:0] A_TXD = 32'h8000_0004;
    localparam logic [31:0] A_TXS = 32'h8000_0008;
    localparam logic [31:0] A_LED = 32'h8000_000C;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
        logic        exp_valid;
        logic        chk_txd;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vq[$];

    data_memory_mmio #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .mem_write        (mem_write),
        .data_memory_addr (data_memory_addr),
        .write_data       (write_data),
        .read_data        (read_data),
        .led              (led),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        mem_write        = we;
        data_memory_addr = a;
        write_data       = wd;
        tx_ready         = rdy;
    endtask

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                       input logic chk_rd, input logic [31:0] exp_rd, input logic [7:0] exp_led,
                       input logic exp_valid, input logic chk_txd, input logic [7:0] exp_txd);
        vec_t v;
        v.we = we; v.addr = a; v.wd = wd; v.rdy = rdy;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_led = exp_led;
        v.exp_valid = exp_valid; v.chk_txd = chk_txd; v.exp_txd = exp_txd;
        vq.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // RAM: same-cycle load sees the old word, no aliasing above RAM size
        add(1, 32'h10,  32'h1111_1111, 0, 0, 32'h0,         8'h00, 0, 0, 8'h00);
        add(1, 32'h10,  32'hDEAD_BEEF, 0, 1, 32'h1111_1111, 8'h00, 0, 0, 8'h00);
        add(0, 32'h13,  32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, 0, 0, 8'h00);
        add(1, 32'h00,  32'hAAAA_AAAA, 0, 0, 32'h0,         8'h00, 0, 0, 8'h00);
        add(1, 32'hFC,  32'h5A5A_5A5A, 0, 0, 32'h0,         8'h00, 0, 0, 8'h00);
        add(0, 32'h100, 32'h0,         0, 1, 32'h0,         8'h00, 0, 0, 8'h00);
        add(1, 32'h101, 32'h1234_5678, 0, 1, 32'h0,         8'h00, 0, 0, 8'h00);
        add(0, 32'h02,  32'h0,         0, 1, 32'hAAAA_AAAA, 8'h00, 0, 0, 8'h00);
        add(0, 32'hFF,  32'h0,         0, 1, 32'h5A5A_5A5A, 8'h00, 0, 0, 8'h00);
        // LED and unmapped space
        add(1, A_LED, 32'h0000_01A5, 0, 1, 32'h0,  8'h00, 0, 0, 8'h00);
        add(0, A_LED, 32'h0,         0, 1, 32'hA5, 8'hA5, 0, 0, 8'h00);
        add(1, 32'h8000_0020, 32'hFFFF_FFFF, 0, 1, 32'h0, 8'hA5, 0, 0, 8'h00);
        add(0, 32'h8000_0010, 32'h0, 0, 1, 32'h0,  8'hA5, 0, 0, 8'h00);
        add(0, A_TXS, 32'h0, 0, 1, 32'h2, 8'hA5, 0, 0, 8'h00);
        // fill FIFO with 0x41..0x48, no drain
        for (int i = 0; i < 8; i++)
            add(1, A_TXD, 32'h41 + i, 0, 1, 32'h0, 8'hA5, (i != 0), (i != 0), 8'h41);
        add(0, A_TXS, 32'h0,  0, 1, 32'h801, 8'hA5, 1, 1, 8'h41);
        add(1, A_TXD, 32'h49, 0, 1, 32'h0,   8'hA5, 1, 1, 8'h41);
        add(0, A_TXS, 32'h0,  0, 1, 32'h805, 8'hA5, 1, 1, 8'h41);
        add(1, A_TXS, 32'h4,  0, 1, 32'h805, 8'hA5, 1, 1, 8'h41);
        add(0, A_TXS, 32'h0,  0, 1, 32'h801, 8'hA5, 1, 1, 8'h41);
        // push into full FIFO while it pops: byte dropped, overflow set
        add(1, A_TXD, 32'h4A, 1, 1, 32'h0,   8'hA5, 1, 1, 8'h41);
        add(0, A_TXS, 32'h0,  0, 1, 32'h704, 8'hA5, 1, 1, 8'h42);
        add(1, A_TXS, 32'hFFFF_FFFB, 0, 1, 32'h704, 8'hA5, 1, 1, 8'h42);
        add(1, A_TXS, 32'h4,  0, 1, 32'h704, 8'hA5, 1, 1, 8'h42);
        // drain 0x42..0x48
        for (int i = 0; i < 7; i++)
            add(0, A_TXS, 32'h0, 1, 1, (32'd7 - i) << 8, 8'hA5, 1, 1, 8'h42 + i);
        add(0, A_TXS, 32'h0, 1, 1, 32'h2, 8'hA5, 0, 0, 8'h00);
        // push into empty FIFO with ready high: no pop that edge
        add(1, A_TXD, 32'h55, 1, 1, 32'h0,   8'hA5, 0, 0, 8'h00);
        add(0, A_TXS, 32'h0,  1, 1, 32'h100, 8'hA5, 1, 1, 8'h55);
        add(0, A_TXS, 32'h0,  0, 1, 32'h2,   8'hA5, 0, 0, 8'h00);
        // simultaneous push/pop on non-empty FIFO keeps order and count
        add(1, A_TXD, 32'h61, 0, 1, 32'h0,   8'hA5, 0, 0, 8'h00);
        add(1, A_TXD, 32'h62, 1, 1, 32'h0,   8'hA5, 1, 1, 8'h61);
        add(0, A_TXS, 32'h0,  0, 1, 32'h100, 8'hA5, 1, 1, 8'h62);
        add(0, A_TXS, 32'h0,  1, 1, 32'h100, 8'hA5, 1, 1, 8'h62);
        add(0, A_TXS, 32'h0,  0, 1, 32'h2,   8'hA5, 0, 0, 8'h00);

        drive(0, 32'h0, 32'h0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_led",   {24'h0, led}, 32'h0);
        check("reset_valid", {31'h0, tx_valid}, 32'h0);
        drive(0, A_TXS, 32'h0, 0);
        #1;
        check("reset_txstat", read_data, 32'h2);
        drive(0, 32'h0, 32'h0, 0);
        rst_n = 1'b1;

        // cycle counter: 5 idle edges, then load and wrap
        for (int i = 0; i < 5; i++)
            tick();
        drive(0, A_CYC, 32'h0, 0);
        #1;
        check("cycle_after_5", read_data, 32'd5);
        drive(1, A_CYC, 32'hFFFF_FFFF, 0);
        tick();
        drive(0, A_CYC, 32'h0, 0);
        #1;
        check("cycle_loaded", read_data, 32'hFFFF_FFFF);
        tick();
        tick();
        check("cycle_wrap", read_data, 32'd1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].we, vq[i].addr, vq[i].wd, vq[i].rdy);
            #1;
            $display("vec %0d we=%0b addr=%h wd=%h rdy=%0b rd=%h led=%h valid=%0b txd=%h",
                     i, vq[i].we, vq[i].addr, vq[i].wd, vq[i].rdy, read_data, led, tx_valid, tx_data);
            if (vq[i].chk_rd)
                check($sformatf("vec%0d_rd", i), read_data, vq[i].exp_rd);
            check($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vq[i].exp_led});
            check($sformatf("vec%0d_valid", i), {31'h0, tx_valid}, {31'h0, vq[i].exp_valid});
            if (vq[i].chk_txd)
                check($sformatf("vec%0d_txd", i), {24'h0, tx_data}, {24'h0, vq[i].exp_txd});
            tick();
        end

        // asynchronous reset with three bytes queued
        for (int i = 0; i < 3; i++) begin
            drive(1, A_TXD, 32'h71 + i, 0);
            tick();
        end
        drive(0, A_TXS, 32'h0, 0);
        #1;
        check("burst_txstat", read_data, 32'h300);
        check("burst_valid", {31'h0, tx_valid}, 32'h1);
        check("burst_txd", {24'h0, tx_data}, 32'h71);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'h0, tx_valid}, 32'h0);
        check("async_led", {24'h0, led}, 32'h0);
        check("async_txstat", read_data, 32'h2);
        drive(0, A_CYC, 32'h0, 0);
        #1;
        check("async_cycle", read_data, 32'h0);
        drive(0, 32'h10, 32'h0, 0);
        #1;
        check("async_ram", read_data, 32'hDEAD_BEEF);
        tick();
        rst_n = 1'b1;
        tick();
        check("ram_retained", read_data, 32'hDEAD_BEEF);
        drive(0, A_TXS, 32'h0, 0);
        #1;
        check("post_reset_txstat", read_data, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
